// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//   Merges MEM/WB retirements and out-of-band Booth multiplier results onto the
//   single register-file write port. Multiplier results queue in a small FIFO;
//   if the FIFO head keeps losing to the pipeline, stall_pipe forces a drain.
// Ports
//   clk, rst                    clock, async active-high reset
//   wb_valid/wb_reg_write/...   MEM/WB retirement slot
//   mul_valid/mul_dest/...      multiplier result handshake (mul_ready = !full)
//   stall_pipe                  upstream must hold MEM/WB this cycle
//   RegWrite/Write_Register/
//   Write_Data                  registered register-file write port
module regfile_writeback_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        wb_reg_write,
  input  logic        wb_mem_to_reg,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_alu_result,
  input  logic [31:0] wb_mem_data,
  input  logic        mul_valid,
  input  logic [4:0]  mul_dest,
  input  logic [31:0] mul_result,
  output logic        mul_ready,
  output logic        stall_pipe,
  output logic        RegWrite,
  output logic [4:0]  Write_Register,
  output logic [31:0] Write_Data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [FIFO_DEPTH-1:0] fifo_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  logic [SW-1:0] starve_cnt;

  logic    fifo_full, fifo_req, starved;
  logic    pipe_req, push, pop;
  wb_ent_t head;
  logic [31:0] wb_data;

  assign fifo_full  = (occ == CW'(FIFO_DEPTH));
  assign fifo_req   = (occ != '0);
  assign starved    = (starve_cnt == SW'(STARVE_LIMIT));
  assign stall_pipe = fifo_req & starved;
  assign mul_ready  = ~fifo_full;

  // wb_* are don't-care during a stall; upstream re-presents them next cycle.
  assign pipe_req = wb_valid & wb_reg_write & (wb_dest != 5'd0) & ~stall_pipe;
  assign pop      = ~pipe_req & fifo_req;
  // Writes to r0 are accepted off the multiplier but never occupy a slot.
  assign push     = mul_valid & ~fifo_full & (mul_dest != 5'd0);

  assign head    = fifo_q[rd_ptr];
  assign wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;

  // Storage carries no reset: occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{dest: mul_dest, data: mul_result};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  // Counts cycles the head loses to the pipeline; saturates so stall holds
  // until the forced pop clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         starve_cnt <= '0;
    else if (pop || !fifo_req)       starve_cnt <= '0;
    else if (pipe_req && !starved)   starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite       <= 1'b0;
      Write_Register <= '0;
      Write_Data     <= '0;
    end else if (pipe_req) begin
      RegWrite       <= 1'b1;
      Write_Register <= wb_dest;
      Write_Data     <= wb_data;
    end else if (pop) begin
      RegWrite       <= 1'b1;
      Write_Register <= head.dest;
      Write_Data     <= head.data;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter
//   Directed scenarios with literal expectations, then a long randomized run.
//   A queue-based model predicts mul_ready/stall_pipe before each edge and the
//   registered write port after it.
module tb_regfile_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk, rst;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_dest;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic        mul_valid;
  logic [4:0]  mul_dest;
  logic [31:0] mul_result;
  logic        mul_ready, stall_pipe, RegWrite;
  logic [4:0]  Write_Register;
  logic [31:0] Write_Data;

  regfile_writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_dest(wb_dest), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .mul_valid(mul_valid), .mul_dest(mul_dest), .mul_result(mul_result),
    .mul_ready(mul_ready), .stall_pipe(stall_pipe),
    .RegWrite(RegWrite), .Write_Register(Write_Register), .Write_Data(Write_Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [36:0] m_q[$];
  int          m_starve = 0;
  logic        exp_rw = 0;
  logic [4:0]  exp_wr = 0;
  logic [31:0] exp_wd = 0;
  bit          last_wb_taken = 1, last_mul_taken = 1;
  bit          log_en = 0;
  logic [4:0]  mul_log[$];

  always begin : compare
    bit m_full, m_stall, p_req, had;
    logic [36:0] ent;
    @(negedge clk); #4;
    if (rst) begin
      m_q.delete(); m_starve = 0;
      exp_rw = 0; exp_wr = 0; exp_wd = 0;
      last_wb_taken = 1; last_mul_taken = 1;
      chk("rst_RegWrite", RegWrite, 0);
      chk("rst_mul_ready", mul_ready, 1);
    end else begin
      m_full  = (m_q.size() == DEPTH);
      had     = (m_q.size() != 0);
      m_stall = had && (m_starve == LIMIT);
      chk("mul_ready", mul_ready, !m_full);
      chk("stall_pipe", stall_pipe, m_stall);
      p_req = wb_valid && wb_reg_write && (wb_dest != 0) && !m_stall;
      if (p_req) begin
        exp_rw = 1; exp_wr = wb_dest;
        exp_wd = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
        if (had && m_starve < LIMIT) m_starve++;
      end else if (had) begin
        ent = m_q.pop_front();
        exp_rw = 1; exp_wr = ent[36:32]; exp_wd = ent[31:0];
        m_starve = 0;
      end else begin
        exp_rw = 0; m_starve = 0;
      end
      if (mul_valid && !m_full && mul_dest != 0) m_q.push_back({mul_dest, mul_result});
      last_wb_taken  = !m_stall;
      last_mul_taken = mul_valid && !m_full;
    end
    @(posedge clk); #1;
    if (!rst) begin
      chk("RegWrite", RegWrite, exp_rw);
      chk("Write_Register", Write_Register, exp_wr);
      chk("Write_Data", Write_Data, exp_wd);
      if (log_en && RegWrite && Write_Register >= 20 && Write_Register <= 22)
        mul_log.push_back(Write_Register);
    end
  end

  task automatic idle();
    wb_valid = 0; wb_reg_write = 0; wb_mem_to_reg = 0; wb_dest = 0;
    wb_alu_result = 0; wb_mem_data = 0;
    mul_valid = 0; mul_dest = 0; mul_result = 0;
  endtask

  task automatic pipe(input logic [4:0] d, input logic [31:0] v);
    wb_valid = 1; wb_reg_write = 1; wb_mem_to_reg = 0; wb_dest = d; wb_alu_result = v;
    wb_mem_data = ~v;
  endtask

  task automatic mul(input logic [4:0] d, input logic [31:0] v);
    mul_valid = 1; mul_dest = d; mul_result = v;
  endtask

  task automatic post_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] d;
    int m;
    idle();
    rst = 1;
    #1;
    chk("reset_RegWrite", RegWrite, 0);
    chk("reset_Write_Register", Write_Register, 0);
    chk("reset_Write_Data", Write_Data, 0);
    chk("reset_mul_ready", mul_ready, 1);
    chk("reset_stall", stall_pipe, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // Single pipeline write
    pipe(5'd5, 32'h0000_00AA);
    post_edge();
    chk("t1_RegWrite", RegWrite, 1);
    chk("t1_Write_Register", Write_Register, 5);
    chk("t1_Write_Data", Write_Data, 32'hAA);
    @(negedge clk); idle();
    post_edge();
    chk("t1_idle_RegWrite", RegWrite, 0);
    chk("t1_idle_hold", Write_Register, 5);

    // r0 writes from either source are dropped
    @(negedge clk); pipe(5'd0, 32'h1111_1111);
    post_edge();
    chk("t2_pipe_r0", RegWrite, 0);
    @(negedge clk); idle(); mul(5'd0, 32'h2222_2222);
    post_edge();
    @(negedge clk); idle();
    #1;
    chk("t2_mul_r0_ready", mul_ready, 1);
    post_edge();
    chk("t2_mul_r0_nowrite", RegWrite, 0);

    // Back-to-back multiplier results with an idle pipeline
    @(negedge clk); mul(5'd9, 32'h1234_5678);
    post_edge();
    chk("t3_same_cycle", RegWrite, 0);
    @(negedge clk); mul(5'd10, 32'hDEAD_BEEF);
    #1 chk("t3_ready1", mul_ready, 1);
    post_edge();
    chk("t3_r9", Write_Register, 9);
    chk("t3_r9_data", Write_Data, 32'h1234_5678);
    @(negedge clk); idle();
    #1 chk("t3_ready2", mul_ready, 1);
    post_edge();
    chk("t3_r10", Write_Register, 10);
    chk("t3_r10_data", Write_Data, 32'hDEAD_BEEF);
    @(negedge clk); idle();

    // Starvation: r12 queued behind four pipeline writes
    @(negedge clk); pipe(5'd31, 32'h31); mul(5'd12, 32'hC0C0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); idle(); pipe(5'(i), 32'(i));
      #1 chk("t4_no_stall", stall_pipe, 0);
      post_edge();
      chk("t4_pipe_wins", Write_Register, 5'(i));
    end
    @(negedge clk); pipe(5'd5, 32'h5);
    #1 chk("t4_stall", stall_pipe, 1);
    post_edge();
    chk("t4_r12", Write_Register, 12);
    chk("t4_r12_data", Write_Data, 32'hC0C0);
    @(negedge clk); pipe(5'd5, 32'h5);
    #1 chk("t4_stall_clear", stall_pipe, 0);
    post_edge();
    chk("t4_r5", Write_Register, 5);
    @(negedge clk); idle();
    @(negedge clk);

    // Full FIFO with a held third push under continuous pipeline traffic
    log_en = 1;
    d = 1; m = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i > 0 && last_wb_taken) d = (d == 19) ? 5'd1 : d + 1'b1;
      pipe(d, {27'h0, d});
      if (i > 0 && last_mul_taken) m++;
      if (m < 3) mul(5'(20 + m), 32'hA000 + 32'(m));
      else begin mul_valid = 0; mul_dest = 0; mul_result = 0; end
      if (i == 2) #1 chk("t5_full", mul_ready, 0);
    end
    @(negedge clk); idle();
    repeat (4) @(negedge clk);
    log_en = 0;
    chk("t5_log_count", mul_log.size(), 3);
    if (mul_log.size() == 3) begin
      chk("t5_order0", mul_log[0], 20);
      chk("t5_order1", mul_log[1], 21);
      chk("t5_order2", mul_log[2], 22);
    end

    // Reset while the FIFO holds two entries and a write is in flight
    @(negedge clk); pipe(5'd3, 32'h3); mul(5'd25, 32'h25);
    @(negedge clk); pipe(5'd4, 32'h4); mul(5'd26, 32'h26);
    @(negedge clk); idle();
    #1 chk("t6_full_pre", mul_ready, 0);
    chk("t6_rw_pre", RegWrite, 1);
    #1 rst = 1;
    #1;
    chk("t6_rst_RegWrite", RegWrite, 0);
    chk("t6_rst_mul_ready", mul_ready, 1);
    chk("t6_rst_stall", stall_pipe, 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 5; i++) begin
      post_edge();
      chk("t6_no_write", RegWrite, 0);
    end

    // Randomized traffic, upstream honouring stall and mul_ready
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (last_wb_taken) begin
        wb_valid      = ((i / 400) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
        wb_reg_write  = ($urandom_range(0, 7) != 0);
        wb_mem_to_reg = 1'($urandom);
        wb_dest       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        wb_alu_result = $urandom;
        wb_mem_data   = $urandom;
      end
      if (last_mul_taken || !mul_valid) begin
        mul_valid  = ($urandom_range(0, 2) == 0);
        mul_dest   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
        mul_result = $urandom;
      end
    end
    @(negedge clk); idle();
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
